// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: responder side of the core instruction-fetch interface.
// It accepts a word fetch, waits WAIT_CYCLES, and returns the word (or an error)
// under a valid/ready handshake. A side port loads program words into the RAM.
// Optional feature macro: IMEM_FETCH_CNT_EN enables the completed-response counter.
module imem_fetch_responder #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_ready,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic        instr_err,
   input  logic        resp_ready,
   input  logic        load_we,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic [31:0] fetch_count
);

   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
   localparam logic        NO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_ready;
   logic          w_accept;
   logic          w_enter_resp;
   logic [3:0]    r_cnt;
   logic [31:0]   r_addr;
   logic          r_valid;
   logic [31:0]   r_instr;
   logic          r_err;
   logic [31:0]   w_rd_addr;
   logic          w_rd_err;
   logic [AW-1:0] w_rd_idx;
   logic          w_ld_err;
   logic [AW-1:0] w_ld_idx;
   logic [31:0]   r_mem [DEPTH];

   // Misaligned, below the base, or past the last word.
   function automatic logic f_addr_err(input logic [31:0] a);
      logic [32:0] diff;
      diff = {1'b0, a} - {1'b0, BASE_ADDR};
      return (a[1:0] != 2'b00) || diff[32] || ((diff >> 2) >= 33'(DEPTH));
   endfunction

   // Word index of a byte address relative to the base.
   function automatic logic [AW-1:0] f_addr_idx(input logic [31:0] a);
      logic [31:0] diff;
      diff = a - BASE_ADDR;
      return AW'(diff >> 2);
   endfunction

   // With no wait the read happens on the accept edge, so use the live address.
   assign w_rd_addr = (r_state == ST_WAIT) ? r_addr : instr_addr;
   assign w_rd_err  = f_addr_err(w_rd_addr);
   assign w_rd_idx  = f_addr_idx(w_rd_addr);
   assign w_ld_err  = f_addr_err(load_addr);
   assign w_ld_idx  = f_addr_idx(load_addr);

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state, ready, accept and read strobes.
   always_comb begin
      w_state_nxt  = r_state;
      w_ready      = 1'b0;
      w_accept     = 1'b0;
      w_enter_resp = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (instr_req) begin
               w_accept     = 1'b1;
               w_enter_resp = NO_WAIT;
               w_state_nxt  = NO_WAIT ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt <= 4'd1) begin
               w_enter_resp = 1'b1;
               w_state_nxt  = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               w_ready = 1'b1;
               if (instr_req) begin
                  w_accept     = 1'b1;
                  w_enter_resp = NO_WAIT;
                  w_state_nxt  = NO_WAIT ? ST_RESP : ST_WAIT;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Address latch, wait counter and registered response.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_addr  <= 32'h0;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         r_instr <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= instr_addr;
            r_cnt  <= WAIT_LD;
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_enter_resp) begin
            r_valid <= 1'b1;
            r_err   <= w_rd_err;
            r_instr <= w_rd_err ? 32'h0 : r_mem[w_rd_idx];
         end else if ((r_state == ST_RESP) && resp_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   // Program-load writes; a same-edge response read still sees the old word.
   always_ff @(posedge clk) begin
      if (load_we && !w_ld_err) r_mem[w_ld_idx] <= load_data;
   end

`ifdef IMEM_FETCH_CNT_EN
   logic [31:0] r_fetch_count;

   // Count every consumed response, errors included.
   always_ff @(posedge clk) begin
      if (!rstn)                       r_fetch_count <= 32'h0;
      else if (r_valid && resp_ready)  r_fetch_count <= r_fetch_count + 32'd1;
   end

   assign fetch_count = r_fetch_count;
`else
   assign fetch_count = 32'h0;
`endif

   assign instr_ready = w_ready;
   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign instr_err   = r_err;

endmodule
